axi4lite_display_driver_param: RTL and testbench

AXI4LITE_DISPLAY_DRIVER_PARAM -- requirements
Module: axi4lite_display_driver_param

---
 rtl/axi4lite_display_driver_param_pkg.sv | 53 +++++
 rtl/axi4lite_display_driver_param_hex7seg.sv | 30 +++
 rtl/axi4lite_display_driver_param.sv | 212 +++++++++++++++++++++
 tb/tb_axi4lite_display_driver_param.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4lite_display_driver_param_pkg.sv
// Shared register map, response codes and reset values for the
// AXI4-Lite multiplexed seven-segment display driver.
package axi4lite_display_driver_param_pkg;

    localparam logic [31:0] OFF_CTRL      = 32'h00;
    localparam logic [31:0] OFF_VALUE     = 32'h04;
    localparam logic [31:0] OFF_MASK      = 32'h08;
    localparam logic [31:0] OFF_BLINK_DIV = 32'h0C;
    localparam logic [31:0] OFF_STATUS    = 32'h10;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_LZB      = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [2:0]  CTRL_RST      = 3'b001;
    localparam logic [31:0] VALUE_RST     = 32'h0;
    localparam logic [31:0] BLINK_DIV_RST = 32'd500;

    typedef enum logic [2:0] {
        REG_CTRL,
        REG_VALUE,
        REG_MASK,
        REG_BLINK_DIV,
        REG_STATUS,
        REG_NONE
    } reg_sel_e;

    function automatic reg_sel_e decode(input logic [31:0] addr);
        reg_sel_e sel;
        case ({addr[31:2], 2'b00})
            OFF_CTRL:      sel = REG_CTRL;
            OFF_VALUE:     sel = REG_VALUE;
            OFF_MASK:      sel = REG_MASK;
            OFF_BLINK_DIV: sel = REG_BLINK_DIV;
            OFF_STATUS:    sel = REG_STATUS;
            default:       sel = REG_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] cur,
                                               input logic [31:0] wd,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? wd[8*b +: 8] : cur[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/axi4lite_display_driver_param_hex7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/axi4lite_display_driver_param.sv
// AXI4-Lite slave driving a multiplexed, active-low seven-segment display
// with per-digit enable, decimal points, blinking and leading-zero blanking.
module axi4lite_display_driver_param
    import axi4lite_display_driver_param_pkg::*;
#(
    parameter int NUM_DIGITS         = 8,
    parameter int REFRESH_DIV        = 100000,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [31:0]                   s_axi_wdata,
    input  logic [3:0]                    s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [31:0]                   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [7:0] DIG_MASK = 8'((1 << NUM_DIGITS) - 1);

    logic [2:0]    ctrl;
    logic [31:0]   value;
    logic [7:0]    digit_en;
    logic [7:0]    dp_mask;
    logic [31:0]   blink_div;
    logic [31:0]   blink_cnt;
    logic          phase;
    logic [PW-1:0] presc;
    logic [2:0]    idx;

    reg_sel_e    wsel;
    reg_sel_e    rsel;
    logic        wr_fire;
    logic        rd_fire;
    logic        wr_ok;
    logic [31:0] wcur;
    logic [31:0] wmerged;
    logic [31:0] rmux;
    logic [1:0]  rresp_n;

    assign wsel    = decode(32'(s_axi_awaddr));
    assign rsel    = decode(32'(s_axi_araddr));
    assign wr_fire = s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
    assign rd_fire = s_axi_arvalid && !s_axi_rvalid;
    assign wr_ok   = (wsel != REG_STATUS) && (wsel != REG_NONE);

    assign s_axi_awready = wr_fire;
    assign s_axi_wready  = wr_fire;
    assign s_axi_arready = rd_fire;

    always_comb begin
        wcur = '0;
        case (wsel)
            REG_CTRL:      wcur = {29'h0, ctrl};
            REG_VALUE:     wcur = value;
            REG_MASK:      wcur = {16'h0, digit_en, dp_mask};
            REG_BLINK_DIV: wcur = blink_div;
            default:       wcur = '0;
        endcase
        wmerged = lane_merge(wcur, s_axi_wdata, s_axi_wstrb);
    end

    always_comb begin
        rmux    = '0;
        rresp_n = RESP_OKAY;
        case (rsel)
            REG_CTRL:      rmux = {29'h0, ctrl};
            REG_VALUE:     rmux = value;
            REG_MASK:      rmux = {16'h0, digit_en, dp_mask};
            REG_BLINK_DIV: rmux = blink_div;
            REG_STATUS:    rmux = {16'(NUM_DIGITS), 12'h0, phase, idx};
            default:       rresp_n = RESP_SLVERR;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl      <= CTRL_RST;
            value     <= VALUE_RST;
            digit_en  <= DIG_MASK;
            dp_mask   <= '0;
            blink_div <= BLINK_DIV_RST;
        end else if (wr_fire) begin
            case (wsel)
                REG_CTRL:      ctrl <= wmerged[2:0];
                REG_VALUE:     value <= wmerged;
                REG_MASK: begin
                    digit_en <= wmerged[15:8] & DIG_MASK;
                    dp_mask  <= wmerged[7:0] & DIG_MASK;
                end
                REG_BLINK_DIV: blink_div <= wmerged;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
        end else if (wr_fire) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    // Read data is captured from the pre-write registers on a shared edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else if (rd_fire) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rmux;
            s_axi_rresp  <= rresp_n;
        end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    logic tick;
    logic blink_act;

    assign tick      = ctrl[CTRL_ENABLE] && (presc == PW'(REFRESH_DIV - 1));
    assign blink_act = ctrl[CTRL_BLINK_EN] && (blink_div != 32'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
            idx   <= '0;
        end else if (!ctrl[CTRL_ENABLE]) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (!blink_act) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (tick) begin
            if (blink_cnt == blink_div - 32'd1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 32'd1;
            end
        end
    end

    logic [3:0]            nibble;
    logic [31:0]           upper;
    logic                  visible;
    logic [6:0]            seg_dec;
    logic [NUM_DIGITS-1:0] an_next;

    assign nibble  = value[{idx, 2'b00} +: 4];
    assign upper   = value >> {idx, 2'b00};
    assign visible = ctrl[CTRL_ENABLE] && digit_en[idx] && phase &&
                     !(ctrl[CTRL_LZB] && (idx != 3'd0) && (upper == 32'd0));

    hex7seg u_hex7seg (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    always_comb begin
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            an_next[i] = !(visible && (idx == 3'(i)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= visible ? seg_dec : 7'h7F;
            dp  <= visible ? ~dp_mask[idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_axi4lite_display_driver_param.sv
// Randomized self-checking bench: bus transactions and every display
// output cycle are compared against a cycle-count based reference model.
module tb_axi4lite_display_driver_param;

    localparam int ND  = 8;
    localparam int REF = 4;
    localparam int AW  = 5;

    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] s_axi_awaddr = '0;
    logic          s_axi_awvalid = 1'b0;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata = '0;
    logic [3:0]    s_axi_wstrb = '0;
    logic          s_axi_wvalid = 1'b0;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready = 1'b0;
    logic [AW-1:0] s_axi_araddr = '0;
    logic          s_axi_arvalid = 1'b0;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready = 1'b0;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;

    axi4lite_display_driver_param #(
        .NUM_DIGITS         (ND),
        .REFRESH_DIV        (REF),
        .C_S_AXI_ADDR_WIDTH (AW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .an            (an),
        .seg           (seg),
        .dp            (dp)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_disp = 1'b0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r = o;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // Reference model state
    logic [31:0] m_ctrl, m_val, m_bd;
    logic [7:0]  m_de, m_dp;
    int          en_cyc, base;
    logic        ph;
    logic [7:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    int          wr_seq = 0;
    int          wr_done;
    logic [4:0]  wr_a;
    logic [31:0] wr_d;
    logic [3:0]  wr_s;

    always @(posedge clock or posedge reset) begin : model
        int ticks, idx, nc, nt;
        logic vis, act, nact;
        logic [31:0] up, c2, v2, b2, mk;
        if (reset) begin
            m_ctrl  <= 32'h1;
            m_val   <= 32'h0;
            m_bd    <= 32'd500;
            m_de    <= 8'hFF;
            m_dp    <= 8'h00;
            en_cyc  <= 0;
            base    <= 0;
            ph      <= 1'b1;
            e_an    <= 8'hFF;
            e_seg   <= 7'h7F;
            e_dp    <= 1'b1;
            wr_done <= wr_seq;
        end else begin
            ticks = en_cyc / REF;
            idx   = ticks % ND;
            up    = m_val >> (4 * idx);
            vis   = m_ctrl[0] && m_de[idx] && ph &&
                    !(m_ctrl[2] && idx > 0 && up == 32'd0);
            e_an  <= vis ? ~(8'h01 << idx) : 8'hFF;
            e_seg <= vis ? HEX[up[3:0]] : 7'h7F;
            e_dp  <= vis ? ~m_dp[idx] : 1'b1;
            act = m_ctrl[1] && m_bd != 32'd0;
            nc  = m_ctrl[0] ? en_cyc + 1 : 0;
            nt  = nc / REF;
            en_cyc <= nc;
            ph <= act ? (((nt - base) / int'(m_bd)) % 2 == 0) : 1'b1;
            if (wr_seq != wr_done) begin
                wr_done <= wr_seq;
                c2 = m_ctrl;
                v2 = m_val;
                b2 = m_bd;
                mk = {16'h0, m_de, m_dp};
                case (wr_a & 5'h1C)
                    5'h00: c2 = merge(m_ctrl, wr_d, wr_s) & 32'h7;
                    5'h04: v2 = merge(m_val, wr_d, wr_s);
                    5'h08: mk = merge(mk, wr_d, wr_s);
                    5'h0C: b2 = merge(m_bd, wr_d, wr_s);
                    default: ;
                endcase
                m_ctrl <= c2;
                m_val  <= v2;
                m_bd   <= b2;
                m_de   <= mk[15:8];
                m_dp   <= mk[7:0];
                nact = c2[1] && b2 != 32'd0;
                if (!act && nact) base <= nt;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_disp && !reset) begin
            check("an", 32'(an), 32'(e_an));
            check("seg", 32'(seg), 32'(e_seg));
            check("dp", 32'(dp), 32'(e_dp));
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                             input logic [3:0] s, input bit hold_b,
                             output logic [1:0] resp);
        @(negedge clock);
        s_axi_awaddr  = a;
        s_axi_wdata   = d;
        s_axi_wstrb   = s;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        wr_a = a;
        wr_d = d;
        wr_s = s;
        wr_seq++;
        #1 check("aw_w_ready", {30'h0, s_axi_awready, s_axi_wready}, 32'h3);
        @(negedge clock);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        check("bvalid_rise", 32'(s_axi_bvalid), 32'h1);
        resp = s_axi_bresp;
        if (!hold_b) begin
            s_axi_bready = 1'b1;
            @(negedge clock);
            s_axi_bready = 1'b0;
            check("bvalid_clr", 32'(s_axi_bvalid), 32'h0);
        end
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        @(negedge clock);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        #1 check("arready", 32'(s_axi_arready), 32'h1);
        @(negedge clock);
        s_axi_arvalid = 1'b0;
        check("rvalid_rise", 32'(s_axi_rvalid), 32'h1);
        d    = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(negedge clock);
        s_axi_rready = 1'b0;
        check("rvalid_clr", 32'(s_axi_rvalid), 32'h0);
    endtask

    function automatic bit rw_mapped(input logic [4:0] a);
        return (a & 5'h1C) <= 5'h0C;
    endfunction

    task automatic wr(input logic [4:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic [1:0] r;
        axi_write(a, d, s, 1'b0, r);
        check("bresp", 32'(r), rw_mapped(a) ? 32'h0 : 32'h2);
    endtask

    task automatic rd_chk(input logic [4:0] a);
        logic [31:0] d, e;
        logic [1:0] r, er;
        er = 2'b00;
        case (a & 5'h1C)
            5'h00:   e = m_ctrl;
            5'h04:   e = m_val;
            5'h08:   e = {16'h0, m_de, m_dp};
            5'h0C:   e = m_bd;
            5'h10:   e = 32'(ND) << 16;
            default: begin e = 32'h0; er = 2'b10; end
        endcase
        axi_read(a, d, r);
        if ((a & 5'h1C) == 5'h10) check("status_hi", d & 32'hFFFF0000, e);
        else check("rdata", d, e);
        check("rresp", 32'(r), 32'(er));
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) @(negedge clock);
        check("rst_an", 32'(an), 32'hFF);
        check("rst_seg_dp", {24'h0, seg, dp}, {24'h0, 7'h7F, 1'b1});
        check("rst_valid", {28'h0, s_axi_bvalid, s_axi_rvalid, s_axi_awready,
              s_axi_arready}, 32'h0);
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_resp", {28'h0, s_axi_bresp, s_axi_rresp}, 32'h0);
        reset = 1'b0;
        chk_disp = 1'b1;

        for (int a = 0; a < 5; a++) rd_chk(5'(a * 4));

        wr(5'h04, 32'h12345678, 4'hF);
        axi_read(5'h04, d, r);
        check("value_rb", d, 32'h12345678);
        check("value_resp", 32'(r), 32'h0);
        axi_read(5'h10, d, r);
        check("status_nd", d >> 16, 32'h0008);

        wr(5'h04, 32'h0, 4'hF);
        wr(5'h04, 32'h00FF00AA, 4'b0101);
        axi_read(5'h04, d, r);
        check("value_strb", d, 32'h00FF00AA);
        rd_chk(5'h04);

        wr(5'h10, 32'hFFFFFFFF, 4'hF);
        wr(5'h14, 32'hFFFFFFFF, 4'hF);
        rd_chk(5'h10);
        rd_chk(5'h18);

        wr(5'h04, 32'h0000000A, 4'hF);
        wr(5'h00, 32'h5, 4'hF);
        repeat (40) @(negedge clock);

        for (int k = 0; k < 6; k++) begin
            wr(5'h04, $urandom >> (4 * $urandom_range(0, 7)), 4'hF);
            wr(5'h04, $urandom, 4'($urandom_range(0, 15)));
            wr(5'h08, $urandom, 4'($urandom_range(0, 15)));
            wr(5'h00, {29'h0, 1'($urandom_range(0, 1)), 2'b01}, 4'h1);
            rd_chk(5'h00);
            rd_chk(5'h04);
            rd_chk(5'h08);
            rd_chk(5'(4 * $urandom_range(0, 7)));
            repeat (36) @(negedge clock);
        end

        wr(5'h08, 32'h0000FF5A, 4'hF);
        wr(5'h04, 32'h89ABCDEF, 4'hF);
        wr(5'h0C, 32'd2, 4'hF);
        wr(5'h00, 32'h3, 4'hF);
        rd_chk(5'h0C);
        repeat (48) @(negedge clock);
        wr(5'h00, 32'h1, 4'hF);
        repeat (12) @(negedge clock);

        wr(5'h00, 32'h0, 4'hF);
        repeat (3) @(negedge clock);
        axi_read(5'h10, d, r);
        check("status_idle", d, 32'h00080008);
        wr(5'h00, 32'h1, 4'hF);
        repeat (8) @(negedge clock);

        wr(5'h00, 32'h5, 4'hF);
        chk_disp = 1'b0;
        axi_write(5'h00, 32'h3, 4'hF, 1'b1, r);
        reset = 1'b1;
        #1 check("rst_bvalid_async", 32'(s_axi_bvalid), 32'h0);
        @(negedge clock);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'h0);
        reset = 1'b0;
        axi_read(5'h00, d, r);
        check("ctrl_after_rst", d, 32'h1);
        chk_disp = 1'b1;
        rd_chk(5'h08);
        repeat (40) @(negedge clock);
        chk_disp = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
